// File: rtl/trap_ctrl_if.sv
// Trap controller request, CSR and redirect signal bundle.
// The controller attaches through the slave modport.
interface trap_ctrl_if;
    logic        exc_req_i;
    logic [31:0] exc_cause_i;
    logic [31:0] exc_pc_i;
    logic        mret_req_i;
    logic [31:0] csr_rdata_i;
    logic [31:0] csr_addr_o;
    logic        csr_we_o;
    logic        csr_re_o;
    logic [31:0] csr_wdata_o;
    logic        csr_except_o;
    logic        exc_ack_o;
    logic        mret_ack_o;
    logic        busy_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    modport slave (
        input  exc_req_i,
        input  exc_cause_i,
        input  exc_pc_i,
        input  mret_req_i,
        input  csr_rdata_i,
        output csr_addr_o,
        output csr_we_o,
        output csr_re_o,
        output csr_wdata_o,
        output csr_except_o,
        output exc_ack_o,
        output mret_ack_o,
        output busy_o,
        output redirect_valid_o,
        output redirect_pc_o
    );

    modport master (
        output exc_req_i,
        output exc_cause_i,
        output exc_pc_i,
        output mret_req_i,
        output csr_rdata_i,
        input  csr_addr_o,
        input  csr_we_o,
        input  csr_re_o,
        input  csr_wdata_o,
        input  csr_except_o,
        input  exc_ack_o,
        input  mret_ack_o,
        input  busy_o,
        input  redirect_valid_o,
        input  redirect_pc_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer: saves mepc/mcause, reads mtvec or
// mepc from the CSR file and redirects fetch.
module trap_ctrl #(
    parameter logic [31:0] ADDR_MEPC   = 32'h341,
    parameter logic [31:0] ADDR_MCAUSE = 32'h342,
    parameter logic [31:0] ADDR_MTVEC  = 32'h305
) (
    input  logic        clk_i,
    input  logic        rst_i,
    trap_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR_EPC,
        WR_CAUSE,
        RD_VEC,
        WAIT_VEC,
        RD_EPC,
        WAIT_EPC,
        REDIRECT
    } state_t;

    state_t      state;
    logic [31:0] cause_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        re_q;
    logic        except_q;
    logic        busy_q;
    logic        rv_q;
    logic [31:0] rpc_q;

    logic        take_exc;
    logic        take_mret;
    logic [31:0] base;
    logic [31:0] vec_off;
    logic [31:0] tgt;

    // Exceptions win over a simultaneous mret; the mret stays pending.
    assign take_exc  = (state == IDLE) && !rst_i && bus.exc_req_i;
    assign take_mret = (state == IDLE) && !rst_i && !bus.exc_req_i
                       && bus.mret_req_i;

    always_comb begin
        base    = {bus.csr_rdata_i[31:2], 2'b00};
        vec_off = {cause_q[29:0], 2'b00};
        tgt     = base;
        if ((state == WAIT_VEC) && (bus.csr_rdata_i[1:0] == 2'b01)
            && cause_q[31]) begin
            tgt = base + vec_off;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cause_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            except_q <= 1'b0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take_exc) begin
                        state   <= WR_EPC;
                        cause_q <= bus.exc_cause_i;
                        busy_q  <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= ADDR_MEPC;
                        wdata_q <= bus.exc_pc_i;
                    end else if (take_mret) begin
                        state    <= RD_EPC;
                        busy_q   <= 1'b1;
                        re_q     <= 1'b1;
                        except_q <= 1'b1;
                        addr_q   <= ADDR_MEPC;
                    end
                end
                WR_EPC: begin
                    state   <= WR_CAUSE;
                    addr_q  <= ADDR_MCAUSE;
                    wdata_q <= cause_q;
                end
                WR_CAUSE: begin
                    state    <= RD_VEC;
                    we_q     <= 1'b0;
                    re_q     <= 1'b1;
                    except_q <= 1'b1;
                    addr_q   <= ADDR_MTVEC;
                    wdata_q  <= '0;
                end
                RD_VEC: begin
                    state <= WAIT_VEC;
                    re_q  <= 1'b0;
                end
                RD_EPC: begin
                    state <= WAIT_EPC;
                    re_q  <= 1'b0;
                end
                WAIT_VEC, WAIT_EPC: begin
                    state    <= REDIRECT;
                    except_q <= 1'b0;
                    addr_q   <= '0;
                    rv_q     <= 1'b1;
                    rpc_q    <= tgt;
                end
                REDIRECT: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    rv_q   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.exc_ack_o        = take_exc;
    assign bus.mret_ack_o       = take_mret;
    assign bus.csr_addr_o       = addr_q;
    assign bus.csr_wdata_o      = wdata_q;
    assign bus.csr_we_o         = we_q;
    assign bus.csr_re_o         = re_q;
    assign bus.csr_except_o     = except_q;
    assign bus.busy_o           = busy_q;
    assign bus.redirect_valid_o = rv_q;
    assign bus.redirect_pc_o    = rpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: transaction-level model with a per-cycle
// compare, plus directed vectors with hand-computed targets.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_ctrl_if ifc();

    trap_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // CSR file responder
    logic [31:0] csr_mtvec = 32'h0;
    logic [31:0] ovr_mepc  = 32'h0;
    logic        ovr_en    = 1'b0;
    logic [31:0] dut_mepc  = 32'h0;
    logic [31:0] wr_mepc   = 32'h0;
    logic [31:0] wr_mcause = 32'h0;
    int          n_wr      = 0;

    always @(posedge clk) begin
        if (ifc.csr_re_o) begin
            case (ifc.csr_addr_o)
                32'h305: ifc.csr_rdata_i <= csr_mtvec;
                32'h341: ifc.csr_rdata_i <= ovr_en ? ovr_mepc : dut_mepc;
                default: ifc.csr_rdata_i <= 32'hDEAD_BEEF;
            endcase
        end else begin
            ifc.csr_rdata_i <= 32'h5A5A_A5A5;
        end
        if (ifc.csr_we_o) begin
            n_wr <= n_wr + 1;
            if (ifc.csr_addr_o == 32'h341) begin
                dut_mepc <= ifc.csr_wdata_o;
                wr_mepc  <= ifc.csr_wdata_o;
            end
            if (ifc.csr_addr_o == 32'h342) wr_mcause <= ifc.csr_wdata_o;
        end
    end

    // Model: one expected output vector per busy cycle after acceptance
    typedef struct {
        logic        we, re, ex, rv, ca, cw;
        logic [31:0] addr, wdata, rpc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] last_pc = 32'h0;
    logic [31:0] m_mepc  = 32'h0;
    bit          mvalid  = 1'b0;
    bit          prev_rv = 1'b0;
    int          rv_cnt  = 0;

    function automatic exp_t ent(logic we, logic re, logic ex, logic rv,
                                 logic ca, logic cw, logic [31:0] addr,
                                 logic [31:0] wdata, logic [31:0] rpc);
        exp_t e;
        e.we = we; e.re = re; e.ex = ex; e.rv = rv;
        e.ca = ca; e.cw = cw;
        e.addr = addr; e.wdata = wdata; e.rpc = rpc;
        return e;
    endfunction

    function automatic logic [31:0] trap_tgt(logic [31:0] mtvec,
                                             logic [31:0] cause);
        logic [31:0] base;
        logic [31:0] off;
        base = mtvec & 32'hFFFF_FFFC;
        off  = (cause & 32'h7FFF_FFFF) * 32'd4;
        if (mtvec[1:0] == 2'b01 && cause[31]) return base + off;
        return base;
    endfunction

    always @(negedge clk) begin : cmp
        exp_t        e;
        bit          idle, ea, ma;
        logic [31:0] t;
        idle = (q.size() == 0);
        ea = idle && !rst && ifc.exc_req_i;
        ma = idle && !rst && !ifc.exc_req_i && ifc.mret_req_i;
        if (mvalid) begin
            e = idle ? ent(0, 0, 0, 0, 1, 1, 0, 0, 0) : q[0];
            chk("exc_ack", 32'(ifc.exc_ack_o), 32'(ea));
            chk("mret_ack", 32'(ifc.mret_ack_o), 32'(ma));
            chk("busy", 32'(ifc.busy_o), 32'(!idle));
            chk("csr_we", 32'(ifc.csr_we_o), 32'(e.we));
            chk("csr_re", 32'(ifc.csr_re_o), 32'(e.re));
            chk("csr_except", 32'(ifc.csr_except_o), 32'(e.ex));
            chk("redirect_valid", 32'(ifc.redirect_valid_o), 32'(e.rv));
            if (e.ca) chk("csr_addr", ifc.csr_addr_o, e.addr);
            if (e.cw) chk("csr_wdata", ifc.csr_wdata_o, e.wdata);
            chk("redirect_pc", ifc.redirect_pc_o, e.rv ? e.rpc : last_pc);
            chk("a_we_except", 32'(ifc.csr_we_o && ifc.csr_except_o), 0);
            chk("a_we_re", 32'(ifc.csr_we_o && ifc.csr_re_o), 0);
            chk("a_rv_twice", 32'(ifc.redirect_valid_o && prev_rv), 0);
            if (e.rv) last_pc = e.rpc;
        end
        if (ifc.redirect_valid_o) rv_cnt++;
        prev_rv = ifc.redirect_valid_o;
        if (rst) begin
            q.delete();
            last_pc = 32'h0;
            mvalid  = 1'b1;
        end else begin
            if (!idle) void'(q.pop_front());
            if (ea) begin
                t = trap_tgt(csr_mtvec, ifc.exc_cause_i);
                m_mepc = ifc.exc_pc_i;
                q.push_back(ent(1, 0, 0, 0, 1, 1, 32'h341, ifc.exc_pc_i, 0));
                q.push_back(ent(1, 0, 0, 0, 1, 1, 32'h342,
                                ifc.exc_cause_i, 0));
                q.push_back(ent(0, 1, 1, 0, 1, 0, 32'h305, 0, 0));
                q.push_back(ent(0, 0, 1, 0, 0, 0, 0, 0, 0));
                q.push_back(ent(0, 0, 0, 1, 0, 0, 0, 0, t));
            end else if (ma) begin
                t = (ovr_en ? ovr_mepc : m_mepc) & 32'hFFFF_FFFC;
                q.push_back(ent(0, 1, 1, 0, 1, 0, 32'h341, 0, 0));
                q.push_back(ent(0, 0, 1, 0, 0, 0, 0, 0, 0));
                q.push_back(ent(0, 0, 0, 1, 0, 0, 0, 0, t));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 exc_ack, 1 mret_ack, 2 redirect_valid
    task automatic wait_sig(input int which, input int lim, output int c,
                            output logic [31:0] pc);
        bit hit;
        hit = 1'b0;
        c   = -1;
        pc  = 32'h0;
        for (int i = 0; i < lim && !hit; i++) begin
            @(negedge clk);
            if ((which == 0 && ifc.exc_ack_o) ||
                (which == 1 && ifc.mret_ack_o) ||
                (which == 2 && ifc.redirect_valid_o)) begin
                hit = 1'b1;
                c   = cyc;
                pc  = ifc.redirect_pc_o;
            end
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_%0d: got no event want event", which);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_trap(input string nm, input logic [31:0] pc,
                            input logic [31:0] cause,
                            input logic [31:0] mtvec,
                            input logic [31:0] exp_pc);
        int          ca, cr;
        logic [31:0] p;
        csr_mtvec = mtvec;
        ifc.exc_pc_i    = pc;
        ifc.exc_cause_i = cause;
        ifc.exc_req_i   = 1'b1;
        wait_sig(0, 10, ca, p);
        ifc.exc_req_i = 1'b0;
        wait_sig(2, 10, cr, p);
        chk({nm, "_lat"}, 32'(cr - ca), 32'd5);
        chk({nm, "_pc"}, p, exp_pc);
        chk({nm, "_model"}, trap_tgt(mtvec, cause), exp_pc);
        chk({nm, "_mepc_wr"}, wr_mepc, pc);
        chk({nm, "_mcause_wr"}, wr_mcause, cause);
    endtask

    initial begin
        int          ca, cr, cm, cr2, w0, rv0;
        logic [31:0] p;
        ifc.exc_req_i   = 1'b0;
        ifc.mret_req_i  = 1'b0;
        ifc.exc_cause_i = 32'h0;
        ifc.exc_pc_i    = 32'h0;
        rst = 1'b1;
        repeat (2) tick();

        // request held while in reset must not be acked
        ifc.exc_pc_i    = 32'h100;
        ifc.exc_cause_i = 32'h2;
        ifc.exc_req_i   = 1'b1;
        csr_mtvec       = 32'h8000_0001;
        tick();
        chk("rst_no_ack", 32'(ifc.exc_ack_o), 0);
        chk("rst_busy", 32'(ifc.busy_o), 0);
        chk("rst_rpc", ifc.redirect_pc_o, 32'h0);
        chk("rst_addr", ifc.csr_addr_o, 32'h0);
        rst = 1'b0;

        run_trap("t_exc2", 32'h100, 32'h2, 32'h8000_0001, 32'h8000_0000);
        run_trap("t_irq7", 32'h200, 32'h8000_0007, 32'h8000_0001,
                 32'h8000_001C);
        run_trap("t_wrap", 32'h204, 32'h8000_0007, 32'hFFFF_FFF1,
                 32'h0000_000C);
        run_trap("t_excv", 32'h208, 32'h0000_000B, 32'h0000_1001,
                 32'h0000_1000);
        run_trap("t_mode3", 32'h20C, 32'h8000_0005, 32'h0000_2003,
                 32'h0000_2000);

        // mret with mepc 0x203
        ovr_mepc = 32'h0000_0203;
        ovr_en   = 1'b1;
        w0 = n_wr;
        ifc.mret_req_i = 1'b1;
        wait_sig(1, 10, cm, p);
        ifc.mret_req_i = 1'b0;
        wait_sig(2, 10, cr, p);
        chk("mret_lat", 32'(cr - cm), 32'd3);
        chk("mret_pc", p, 32'h0000_0200);
        chk("mret_no_wr", 32'(n_wr - w0), 0);
        ovr_en = 1'b0;

        // simultaneous exc and mret: trap first, mret right after
        csr_mtvec       = 32'h1000_0001;
        ifc.exc_pc_i    = 32'h0000_0457;
        ifc.exc_cause_i = 32'h8000_0003;
        ifc.exc_req_i   = 1'b1;
        ifc.mret_req_i  = 1'b1;
        wait_sig(0, 10, ca, p);
        ifc.exc_req_i = 1'b0;
        wait_sig(2, 10, cr, p);
        chk("both_trap_lat", 32'(cr - ca), 32'd5);
        chk("both_trap_pc", p, 32'h1000_000C);
        wait_sig(1, 10, cm, p);
        ifc.mret_req_i = 1'b0;
        chk("both_mret_ack_cyc", 32'(cm - cr), 32'd1);
        wait_sig(2, 10, cr2, p);
        chk("both_mret_lat", 32'(cr2 - cm), 32'd3);
        chk("both_mret_pc", p, 32'h0000_0454);

        // reset during WR_CAUSE aborts; held request re-acked
        csr_mtvec       = 32'h8000_0001;
        ifc.exc_pc_i    = 32'h300;
        ifc.exc_cause_i = 32'h8000_0002;
        ifc.exc_req_i   = 1'b1;
        wait_sig(0, 10, ca, p);
        tick();
        chk("abort_in_wr_cause", ifc.csr_addr_o, 32'h342);
        rst = 1'b1;
        rv0 = rv_cnt;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(ifc.busy_o), 0);
        chk("abort_we", 32'(ifc.csr_we_o), 0);
        chk("abort_rv", 32'(ifc.redirect_valid_o), 0);
        chk("abort_rpc", ifc.redirect_pc_o, 32'h0);
        wait_sig(0, 10, cr, p);
        chk("abort_reack_cyc", 32'(cr - ca), 32'd3);
        ifc.exc_req_i = 1'b0;
        wait_sig(2, 10, cr2, p);
        chk("abort_lat", 32'(cr2 - cr), 32'd5);
        chk("abort_pc", p, 32'h8000_0008);
        chk("abort_rv_count", 32'(rv_cnt - rv0), 32'd1);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: ADDR_MEPC, 32'h341, CSR address of mepc.
REQ-002 Parameter: ADDR_MCAUSE, 32'h342, CSR address of mcause.
REQ-003 Parameter: ADDR_MTVEC, 32'h305, CSR address of mtvec.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 exc_req_i  in  1  exception/interrupt request, level, held until exc_ack_o.
REQ-007 exc_cause_i  in  32  cause code; bit31=1 interrupt, bit31=0 exception.
REQ-008 exc_pc_i  in  32  PC of the trapping instruction.
REQ-009 mret_req_i  in  1  trap-return request, level, held until mret_ack_o.
REQ-010 csr_rdata_i  in  32  CSR file read data, valid the cycle after a read is issued.
REQ-011 csr_addr_o  out  32  CSR file address.
REQ-012 csr_we_o / csr_re_o  out  1 each  CSR file write / read enable.
REQ-013 csr_wdata_o  out  32  CSR file write data.
REQ-014 csr_except_o  out  1  drives the CSR file exception-mode input.
REQ-015 exc_ack_o / mret_ack_o  out  1 each  single-cycle request acceptance pulses.
REQ-016 busy_o  out  1  high in every state except IDLE.
REQ-017 redirect_valid_o  out  1  single-cycle pulse; redirect_pc_o valid.
REQ-018 redirect_pc_o  out  32  fetch target; holds its last value between pulses.

Function
REQ-019 FSM states: IDLE, WR_EPC, WR_CAUSE, RD_VEC, WAIT_VEC, RD_EPC, WAIT_EPC, REDIRECT; all CSR and handshake outputs are Moore-decoded from state, except the ack pulses (REQ-020).
REQ-020 IDLE: exc_req_i=1 -> exc_ack_o=1 same cycle, latch exc_pc_i/exc_cause_i, go WR_EPC; else mret_req_i=1 -> mret_ack_o=1, go RD_EPC; else stay.
REQ-021 Simultaneous exc_req_i and mret_req_i in IDLE: exception wins; mret_req_i stays pending, is not acked, and is accepted on a later IDLE cycle.
REQ-022 Requests arriving outside IDLE are not acked and are not lost; requesters hold them.
REQ-023 WR_EPC: csr_we_o=1, csr_addr_o=ADDR_MEPC, csr_wdata_o=latched PC, csr_except_o=0; next WR_CAUSE.
REQ-024 WR_CAUSE: csr_we_o=1, csr_addr_o=ADDR_MCAUSE, csr_wdata_o=latched cause, csr_except_o=0; next RD_VEC.
REQ-025 RD_VEC: csr_re_o=1, csr_except_o=1, csr_addr_o=ADDR_MTVEC; next WAIT_VEC.
REQ-026 WAIT_VEC: csr_except_o=1, csr_re_o=0; capture csr_rdata_i at the closing edge; next REDIRECT.
REQ-027 RD_EPC: csr_re_o=1, csr_except_o=1, csr_addr_o=ADDR_MEPC; next WAIT_EPC. WAIT_EPC: as WAIT_VEC; next REDIRECT.
REQ-028 Trap target: base={mtvec[31:2],2'b00}; if mtvec[1:0]==2'b01 and cause[31]=1, then target=base+(cause[30:0]<<2), truncated to 32 bits (wraps modulo 2^32); otherwise target=base.
REQ-029 Return target = {mepc[31:2],2'b00}.
REQ-030 REDIRECT: redirect_valid_o=1 and redirect_pc_o=target for exactly one cycle; next IDLE. No request is accepted in REDIRECT.
REQ-031 Writes are issued only with csr_except_o=0; csr_we_o and csr_re_o are never both 1; csr_except_o=1 only in RD_VEC, WAIT_VEC, RD_EPC and WAIT_EPC.
REQ-032 Idle outputs: csr_we_o=csr_re_o=csr_except_o=0, csr_addr_o=0, csr_wdata_o=0.
REQ-033 Latency, counting the ack cycle as cycle 0: trap redirect_valid_o at cycle 5; mret redirect_valid_o at cycle 3.

Reset
REQ-034 rst_i=1 at a rising edge forces IDLE in any state, with effect at the next cycle; the aborted sequence produces no further CSR access and no redirect.
REQ-035 After reset: all outputs 0, including redirect_pc_o; latched PC, cause and CSR data registers are 0.
REQ-036 While rst_i=1, no request is acked.

Verification
REQ-037 exc_req, cause=32'h2, pc=32'h100, mtvec reads 32'h8000_0001 -> mepc write 0x100, mcause write 0x2, redirect 32'h8000_0000 at cycle 5.
REQ-038 Cause 32'h8000_0007, mtvec reads 32'h8000_0001 -> redirect 32'h8000_001C; mtvec reads 32'hFFFF_FFF1 with cause 32'h8000_0007 -> redirect 32'h0000_000C (wrap).
REQ-039 mret_req, mepc reads 32'h0000_0203 -> redirect 32'h0000_0200 at cycle 3; no write is issued.
REQ-040 exc_req and mret_req together -> exc_ack only; trap sequence completes; mret_ack on the first IDLE cycle after REDIRECT.
REQ-041 rst_i pulsed during WR_CAUSE -> next cycle IDLE, all outputs 0, no redirect_valid_o; a held exc_req is re-acked after reset deasserts.
REQ-042 Assertions checked on every cycle: csr_we_o implies !csr_except_o; !(csr_we_o && csr_re_o); redirect_valid_o never high for 2 consecutive cycles.
